// File: rtl/pwm_multi.sv
// Multi-channel frame-synchronous PWM generator with double-buffered duty
// registers, arm gating and a write-activity watchdog that forces outputs low.
`timescale 1ns/1ps
module pwm_multi #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 16,
  parameter int          PRESCALE       = 50,
  parameter int          FRAME_TICKS    = 20000,
  parameter int unsigned MIN_PULSE      = 32'h0000_098C,
  parameter int          TIMEOUT_FRAMES = 10,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              duty_wr,
  input  logic [CH_W-1:0]   duty_ch,
  input  logic [CNT_W-1:0]  duty_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              failsafe
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WD_W = ($clog2(TIMEOUT_FRAMES + 1) > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] FR_LAST    = CNT_W'(FRAME_TICKS - 1);
  localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(TIMEOUT_FRAMES);
  localparam logic [WD_W-1:0]  WD_PRE     = WD_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W:0]   MIN_EXT    = (CNT_W + 1)'(MIN_PULSE);
  localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  logic                           arm_d_q;
  logic [PS_W-1:0]                presc_q, presc_d;
  logic [CNT_W-1:0]               frame_cnt_q, frame_cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   staging_q, staging_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   active_q, active_d;
  logic [NUM_CH-1:0]              en_active_q, en_active_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic [NUM_CH-1:0]              pwm_q, pwm_d;
  logic                           frame_start_q, frame_start_d;
  logic                           failsafe_q, failsafe_d;

  logic           run, tick, wrap, load, valid_wr, expire;
  logic [CNT_W:0] lim;

  // The arm-rise load cycle is treated like the disarmed state (timing held
  // at 0, outputs low) so every frame, first or not, starts identically.
  always_comb begin
    run      = arm && arm_d_q;
    tick     = run && (presc_q == PS_LAST);
    wrap     = tick && (frame_cnt_q == FR_LAST);
    load     = (arm && !arm_d_q) || wrap;
    valid_wr = duty_wr && ({1'b0, duty_ch} < NUM_CH_EXT);
    expire   = (TIMEOUT_FRAMES != 0) && wrap && !valid_wr && (wd_q == WD_PRE);
  end

  always_comb begin
    presc_d       = '0;
    frame_cnt_d   = '0;
    if (run) begin
      presc_d     = tick ? '0 : presc_q + 1'b1;
      frame_cnt_d = frame_cnt_q;
      if (tick) frame_cnt_d = wrap ? '0 : frame_cnt_q + 1'b1;
    end

    wd_d = wd_q;
    if (valid_wr)                  wd_d = '0;
    else if (wrap && wd_q != WD_MAX) wd_d = wd_q + 1'b1;

    failsafe_d = failsafe_q;
    if (valid_wr)    failsafe_d = 1'b0;
    else if (expire) failsafe_d = 1'b1;

    staging_d = staging_q;
    if (expire)        staging_d = '0;
    else if (valid_wr) staging_d[duty_ch] = duty_data;

    // An expiring wrap loads the just-cleared staging, so outputs stay low
    // after a recovery write until the following load.
    active_d    = active_q;
    en_active_d = en_active_q;
    if (load) begin
      active_d    = expire ? '0 : staging_q;
      en_active_d = ch_en;
    end

    frame_start_d = load;

    pwm_d = '0;
    lim   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      lim      = {1'b0, active_q[i]} + MIN_EXT;
      pwm_d[i] = run && !failsafe_q && en_active_q[i] && (active_q[i] != '0) &&
                 ({1'b0, frame_cnt_q} < lim);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arm_d_q       <= 1'b0;
      presc_q       <= '0;
      frame_cnt_q   <= '0;
      staging_q     <= '0;
      active_q      <= '0;
      en_active_q   <= '0;
      wd_q          <= '0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      failsafe_q    <= 1'b0;
    end else begin
      arm_d_q       <= arm;
      presc_q       <= presc_d;
      frame_cnt_q   <= frame_cnt_d;
      staging_q     <= staging_d;
      active_q      <= active_d;
      en_active_q   <= en_active_d;
      wd_q          <= wd_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      failsafe_q    <= failsafe_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign failsafe    = failsafe_q;

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, channel count (1..16); CNT_W, default 16, duty/frame counter width; PRESCALE, default 50, clk cycles per tick (>=1); FRAME_TICKS, default 20000, ticks per frame (<2^CNT_W); MIN_PULSE, default 16'h098C, fixed pulse offset in ticks; TIMEOUT_FRAMES, default 10, failsafe frame count (0 = disabled).
REQ-002 CH_W SHALL equal ceil(log2(NUM_CH)), minimum 1.
REQ-003 Reset SHALL be resetn, asynchronous, active-low; clock SHALL be clk.
REQ-004 Ports, in order:
- clk  in  1  system clock
- resetn  in  1  async active-low reset
- arm  in  1  output-stage enable; low = outputs held low, frame timing held at 0
- ch_en  in  NUM_CH  per-channel enable
- duty_wr  in  1  one-cycle write strobe
- duty_ch  in  CH_W  write channel index
- duty_data  in  CNT_W  duty value, ticks beyond MIN_PULSE
- pwm_out  out  NUM_CH  registered pulse outputs
- frame_start  out  1  one-cycle pulse on each load event
- failsafe  out  1  watchdog-expired flag

Function
REQ-005 Prescaler SHALL count 0..PRESCALE-1 while arm=1; tick = 1 in the cycle the count equals PRESCALE-1; then wrap to 0.
REQ-006 Frame counter SHALL advance on tick, counting 0..FRAME_TICKS-1 and wrapping to 0.
REQ-007 Load event SHALL occur on (a) the first clk with arm=1 after arm=0 (arm_d register), or (b) the cycle the frame counter wraps; frame_start SHALL equal 1 exactly in that cycle.
REQ-008 duty_wr with duty_ch<NUM_CH SHALL write staging[duty_ch] <= duty_data; duty_ch>=NUM_CH SHALL be ignored (no staging change, no watchdog kick).
REQ-009 On a load event, active[i] <= staging[i] and en_active[i] <= ch_en[i] for all i; a write in the load cycle SHALL update staging only, taking effect at the next load event.
REQ-010 Mid-frame changes to staging or ch_en SHALL NOT alter the current frame's pulses.
REQ-011 Channel i qualifies high when arm=1, failsafe=0, en_active[i]=1, active[i]!=0, and frame_cnt < active[i]+MIN_PULSE, sum computed at CNT_W+1 bits (no wrap).
REQ-012 pwm_out[i] SHALL be the registered qualification; one-clk latency from frame_cnt.
REQ-013 If active[i]+MIN_PULSE >= FRAME_TICKS, pwm_out[i] SHALL stay high for the whole frame (100%); active[i]=0 SHALL give 0%.
REQ-014 arm=0 SHALL drive prescaler and frame counter to 0 and all pwm_out low on the next clk; staging, active and the watchdog counter SHALL be retained.
REQ-015 Watchdog counter SHALL increment at each frame wrap while arm=1, clear to 0 on each valid write, and saturate at TIMEOUT_FRAMES.
REQ-016 When the counter reaches TIMEOUT_FRAMES (nonzero), failsafe SHALL set in that cycle's register update, all staging SHALL clear to 0, and pwm_out SHALL go low on the next clk.
REQ-017 A valid write while failsafe=1 SHALL clear failsafe on the next clk; outputs resume at the next load event using the written staging value.
REQ-018 A valid write coinciding with the expiring frame wrap SHALL win: no failsafe, counter cleared.
REQ-019 TIMEOUT_FRAMES=0 SHALL hold failsafe at 0 permanently.

Reset
REQ-020 resetn low SHALL asynchronously clear prescaler, frame counter, staging, active, en_active, arm_d, watchdog counter, pwm_out, frame_start and failsafe to 0.
REQ-021 After resetn release, no load event SHALL occur until arm is sampled high.

Verification (NUM_CH=2, PRESCALE=2, FRAME_TICKS=100, MIN_PULSE=10, TIMEOUT_FRAMES=3)
REQ-022 Reset asserted mid-pulse -> pwm_out=0, failsafe=0, frame_start=0 immediately; no output until arm re-sampled high.
REQ-023 Write ch0=20, ch_en=2'b11, arm high -> frame_start at first armed clk; pwm_out[0] high 60 clk of each 200-clk frame; pwm_out[1] low because its duty is 0.
REQ-024 Write ch0=50 at frame tick 5 -> current frame high 60 clk, next frame high 120 clk; ch_en[0] dropped mid-frame -> current pulse completes, next frame low.
REQ-025 Write ch1=95 -> pwm_out[1] high all 200 clk every frame; write ch1=0 -> low from the next frame.
REQ-026 No writes for 3 frame wraps -> failsafe=1 at third wrap, both outputs low next clk; write ch0=20 -> failsafe=0 next clk, 60-clk pulse from next load.
REQ-027 arm dropped at tick 10 of a 30-tick pulse -> pwm_out low next clk; arm re-raised -> frame_start immediately, full 60-clk pulse from tick 0.
